// File: rtl/timer_pkg.sv
// Shared types and default widths for the interval-timer controller.
package timer_pkg;

    // FSM state encoding; code 3 is unused and is treated as IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int DEF_CNT_W = 4;
    localparam int DEF_PSC_W = 4;

endpackage

// File: rtl/timer_prescaler.sv
// Clock prescaler: counts 0..presc while enabled and emits a one-cycle tick
// in the cycle where the count equals presc, then wraps to 0.
module timer_prescaler
    import timer_pkg::*;
#(
    parameter int PSC_W = DEF_PSC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clear,
    input  logic [PSC_W-1:0] presc,
    output logic             tick
);

    logic [PSC_W-1:0] cnt_q;
    logic [PSC_W-1:0] cnt_d;

    assign tick = en && (cnt_q == presc);

    // Next prescaler count: clear has priority, otherwise advance or wrap on tick.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + PSC_W'(1);
        end
    end

    // Prescaler count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/timer_ctrl.sv
// Programmable interval-timer controller: load/run/done sequencing of a
// down-counter driven by a prescaler tick, with a sticky interrupt request.
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int PSC_W = DEF_PSC_W
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             stop,
    input  logic             mode_periodic,
    input  logic [CNT_W-1:0] load_val,
    input  logic [PSC_W-1:0] presc,
    input  logic             irq_ack,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             tc,
    output logic             irq,
    output logic [1:0]       state
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PSC_W-1:0] presc_q, presc_d;
    logic             mode_q,  mode_d;
    logic             tc_q,    tc_d;
    logic             irq_q,   irq_d;

    logic             in_run;
    logic             psc_en;
    logic             psc_clr;
    logic             tick;
    logic             irq_set;

    assign in_run = (state_q == ST_RUN);

    // The prescaler only advances on plain RUN cycles; any start, stop or
    // non-RUN cycle restarts it from 0 so the first tick period is full.
    assign psc_en  = in_run && !stop && !start;
    assign psc_clr = !in_run || stop || start;

    timer_prescaler #(
        .PSC_W (PSC_W)
    ) u_presc (
        .clk   (clk),
        .rst   (clr),
        .en    (psc_en),
        .clear (psc_clr),
        .presc (presc_q),
        .tick  (tick)
    );

    // Next-state, counter, terminal-count and interrupt logic (stop > start > tick).
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        presc_d = presc_q;
        mode_d  = mode_q;
        tc_d    = 1'b0;
        irq_set = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (start) begin
                    count_d = load_val;
                    presc_d = presc;
                    mode_d  = mode_periodic;
                end else if (tick) begin
                    if (count_q != '0) begin
                        count_d = count_q - CNT_W'(1);
                    end else begin
                        tc_d    = 1'b1;
                        irq_set = 1'b1;
                        if (mode_q) begin
                            count_d = load_val;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                end
            end
            ST_DONE: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (start) begin
                    state_d = ST_RUN;
                    count_d = load_val;
                    presc_d = presc;
                    mode_d  = mode_periodic;
                end
            end
            default: begin
                // IDLE and the unused code 3 behave identically.
                state_d = ST_IDLE;
                if (!stop && start) begin
                    state_d = ST_RUN;
                    count_d = load_val;
                    presc_d = presc;
                    mode_d  = mode_periodic;
                end
            end
        endcase

        // Sticky interrupt: a new set beats a simultaneous acknowledge.
        if (irq_set) begin
            irq_d = 1'b1;
        end else if (irq_ack) begin
            irq_d = 1'b0;
        end else begin
            irq_d = irq_q;
        end
    end

    // Controller state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            presc_q <= '0;
            mode_q  <= 1'b0;
            tc_q    <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            presc_q <= presc_d;
            mode_q  <= mode_d;
            tc_q    <= tc_d;
            irq_q   <= irq_d;
        end
    end

    assign count = count_q;
    assign busy  = in_run;
    assign tc    = tc_q;
    assign irq   = irq_q;
    assign state = state_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed testbench for timer_ctrl with hand-computed expectations.
module tb_timer_ctrl;

    logic       clk = 1'b0;
    logic       clr;
    logic       start;
    logic       stop;
    logic       mode_periodic;
    logic [3:0] load_val;
    logic [3:0] presc;
    logic       irq_ack;
    logic [3:0] count;
    logic       busy;
    logic       tc;
    logic       irq;
    logic [1:0] state;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    timer_ctrl #(
        .CNT_W (4),
        .PSC_W (4)
    ) dut (
        .clk           (clk),
        .clr           (clr),
        .start         (start),
        .stop          (stop),
        .mode_periodic (mode_periodic),
        .load_val      (load_val),
        .presc         (presc),
        .irq_ack       (irq_ack),
        .count         (count),
        .busy          (busy),
        .tc            (tc),
        .irq           (irq),
        .state         (state)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Advance n rising edges; sample/drive 1 time unit after each edge.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        clr = 1'b1; start = 1'b0; stop = 1'b0; mode_periodic = 1'b0;
        load_val = '0; presc = '0; irq_ack = 1'b0;
        cyc(2);
        clr = 1'b0;
        chk("rst_state", state, 0);
        chk("rst_count", count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tc", tc, 0);
        chk("rst_irq", irq, 0);

        // Reset in the middle of RUN with count=5.
        presc = 4'd3; load_val = 4'd5; start = 1'b1;
        cyc(1);
        start = 1'b0;
        chk("mid_count", count, 5);
        chk("mid_state", state, 1);
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        chk("midrst_count", count, 0);
        chk("midrst_state", state, 0);
        chk("midrst_tc", tc, 0);
        chk("midrst_irq", irq, 0);
        chk("midrst_busy", busy, 0);

        // One-shot, presc=0, load=3.
        presc = 4'd0; load_val = 4'd3; mode_periodic = 1'b0; start = 1'b1;
        cyc(1);
        start = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            chk("os_count", count, 4 - k);
            chk("os_tc_low", tc, 0);
            chk("os_busy", busy, 1);
            cyc(1);
        end
        chk("os_tc", tc, 1);
        chk("os_state_done", state, 2);
        chk("os_irq", irq, 1);
        chk("os_busy_done", busy, 0);
        chk("os_count_done", count, 0);
        cyc(1);
        chk("os_tc_one", tc, 0);
        chk("os_irq_hold", irq, 1);
        chk("os_done_hold", state, 2);
        irq_ack = 1'b1;
        cyc(1);
        irq_ack = 1'b0;
        chk("os_irq_ack", irq, 0);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        chk("done_stop", state, 0);

        // Periodic, presc=1, load=2: tc in cycles 7, 13, 19.
        presc = 4'd1; load_val = 4'd2; mode_periodic = 1'b1; start = 1'b1;
        cyc(1);
        start = 1'b0; mode_periodic = 1'b0;
        for (int k = 1; k <= 19; k++) begin
            chk("per_tc", tc, (k == 7 || k == 13 || k == 19) ? 1 : 0);
            chk("per_busy", busy, 1);
            if (k == 7 || k == 13 || k == 19) begin
                chk("per_reload", count, 2);
                chk("per_irq", irq, 1);
            end
            if (k < 19) cyc(1);
        end
        stop = 1'b1; irq_ack = 1'b1;
        cyc(1);
        stop = 1'b0; irq_ack = 1'b0;
        chk("per_stop_state", state, 0);
        chk("per_stop_irq", irq, 0);

        // start+stop together in RUN at count=4.
        presc = 4'd0; load_val = 4'd7; mode_periodic = 1'b0; start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(3);
        chk("ss_count4", count, 4);
        start = 1'b1; stop = 1'b1;
        cyc(1);
        start = 1'b0; stop = 1'b0;
        chk("ss_state", state, 0);
        chk("ss_hold", count, 4);
        chk("ss_busy", busy, 0);
        cyc(2);
        chk("ss_hold2", count, 4);
        load_val = 4'd9; start = 1'b1;
        cyc(1);
        start = 1'b0;
        chk("rs_count", count, 9);
        chk("rs_state", state, 1);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        chk("stop_hold", count, 9);
        chk("stop_state", state, 0);

        // irq handshake: periodic load=1 presc=0 gives tc in cycles 3, 5, 7.
        presc = 4'd0; load_val = 4'd1; mode_periodic = 1'b1; start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(2);
        chk("hs_tc1", tc, 1);
        chk("hs_irq1", irq, 1);
        cyc(1);
        chk("hs_irq_hold", irq, 1);
        irq_ack = 1'b1;
        cyc(1);
        chk("hs_tc2", tc, 1);
        chk("hs_set_wins", irq, 1);
        cyc(1);
        irq_ack = 1'b0;
        chk("hs_ack_clear", irq, 0);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;

        // load=0 periodic, presc=2: tc in cycles 4, 7, 10.
        presc = 4'd2; load_val = 4'd0; mode_periodic = 1'b1; start = 1'b1;
        cyc(1);
        start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            chk("z_tc", tc, (k > 1 && (k % 3) == 1) ? 1 : 0);
            chk("z_count", count, 0);
            chk("z_busy", busy, 1);
            cyc(1);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/timer_ctrl.md
Name: timer_ctrl

Overview:
- Programmable interval-timer controller: sequences a synchronous down-counter through load, run, pause and terminal-count phases, with a clock prescaler and an interrupt request/acknowledge handshake.
- Sits above the counter datapath in the timer subsystem.
- Replaces free-running ripple counting with a software-visible, single-clock timer: one-shot or periodic, start/stop control, sticky interrupt.

Parameters:
- CNT_W, 4, width of the down-counter and load value.
- PSC_W, 4, width of the prescaler divide field.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- clr  input  1  synchronous active-high reset.
- start  input  1  level sampled per cycle; loads load_val and runs.
- stop  input  1  level sampled per cycle; halts counting.
- mode_periodic  input  1  1 = auto-reload at terminal count; 0 = one-shot. Sampled only on the start cycle.
- load_val  input  CNT_W  reload value; sampled on start and on each periodic reload.
- presc  input  PSC_W  tick period is presc+1 clocks; sampled on start.
- irq_ack  input  1  clears irq.
- count  output  CNT_W  current counter value.
- busy  output  1  high in RUN.
- tc  output  1  registered one-cycle terminal-count pulse.
- irq  output  1  sticky interrupt request.
- state  output  2  FSM state code, for debug.

Behaviour:
- Reset: clk rising edge with clr=1. Forces state=IDLE, count=0, prescaler=0, tc=0, irq=0, busy=0 and clears latched mode/presc. Reset mid-RUN aborts immediately; no tc is produced.
- States: IDLE=0, RUN=1, DONE=2 (3 unused; decodes to IDLE).
- Priority per cycle: clr > stop > start > tick.
- IDLE/DONE + start: next cycle count=load_val, prescaler=0, mode and presc latched, state=RUN.
- RUN + stop: next cycle state=IDLE. count holds its value; the prescaler is cleared. A pending tc or irq set in the same cycle is suppressed.
- RUN + start (no stop): restart. Same effect as start from IDLE.
- start and stop in the same cycle: stop wins, in every state.
- Tick: prescaler counts 0..presc_latched. A tick occurs in a RUN cycle where prescaler==presc_latched; the prescaler then wraps to 0.
- On a tick with count!=0: count decrements by 1.
- On a tick with count==0:
  - tc=1 on the next cycle only.
  - irq set.
  - Periodic: count=load_val and stay in RUN.
  - One-shot: count stays 0 and state=DONE.
- Timing with presc=0 and load N, start sampled at edge 0:
  - count=N during cycle 1.
  - count=0 during cycle N+1.
  - tc high during cycle N+2.
  - Periodic period = (N+1)*(presc+1) clocks.
- load_val=0: tc on the first tick. In periodic mode this gives tc every presc+1 clocks.
- irq: set on tc, cleared by irq_ack. A set and an ack in the same cycle: set wins. An ack while irq=0 is ignored.
- DONE: count frozen at 0, busy=0. start leaves DONE; stop moves DONE to IDLE.
- Arithmetic: all counters are unsigned and no wrap below 0 occurs (the reload or DONE transition preempts it). The prescaler compare uses the latched PSC_W-bit value.

Decomposition:
- Package timer_pkg:
  - state enum (ST_IDLE, ST_RUN, ST_DONE).
  - Default CNT_W/PSC_W localparams.
- Sub-module timer_prescaler (enable, clear, presc in; tick out) is natural and reusable.
- FSM, down-counter and irq logic stay in timer_ctrl.

Test Plan:
- Reset: drive clr=1 mid-RUN with count=5 -> next cycle count=0, state=0, tc=0, irq=0, busy=0.
- One-shot: presc=0, load_val=3, start pulse at edge 0 -> count 3,2,1,0 in cycles 1-4; tc=1 only in cycle 5; state=DONE; irq=1 until irq_ack.
- Periodic with prescaler: presc=1, load_val=2, mode_periodic=1 -> tc pulses every 6 clocks for at least 3 periods; count reloads to 2 after each tc.
- Stop/start priority: assert start and stop together during RUN at count=4 -> state=IDLE, count holds 4. Later a start alone -> count=load_val, RUN.
- irq handshake: irq_ack asserted in the same cycle a new tc sets irq -> irq remains 1. Ack on the following cycle -> irq=0.
- load_val=0 in periodic mode with presc=2 -> tc every 3 clocks; count stays 0; busy=1 throughout.
